// File: rtl/arp_pkg.sv
// rtl/arp_pkg.sv - shared constants for the arpeggiating wavetable voice
// Just-intonation ratio table (Q2.8), mode encodings and sequencer direction type.
package arp_pkg;

  localparam int RATIO_FRAC = 8;
  localparam int RATIO_W    = 10;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_UP     = 2'd1;
  localparam logic [1:0] MODE_DOWN   = 2'd2;
  localparam logic [1:0] MODE_UPDOWN = 2'd3;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef logic [RATIO_W-1:0] ratio_t;

  // 1, 5/4, 3/2, 2 : root, major third, fifth, octave
  function automatic ratio_t note_ratio(input logic [1:0] idx);
    case (idx)
      2'd0:    return ratio_t'(256);
      2'd1:    return ratio_t'(320);
      2'd2:    return ratio_t'(384);
      default: return ratio_t'(512);
    endcase
  endfunction

endpackage

// File: rtl/arp_note_seq.sv
// rtl/arp_note_seq.sv - arp note sequencer: note-length counter, direction and note index
// Holds index 0 whenever inactive so re-entry always starts on the root note.
module arp_note_seq
  import arp_pkg::*;
#(
  parameter int NUM_NOTES  = 4,
  parameter int NOTE_TICKS = 50_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       active_i,
  input  logic [1:0] mode_i,
  output logic [1:0] note_idx_o
);

  localparam int         NT_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [1:0] LAST = 2'(NUM_NOTES - 1);

  logic [NT_W-1:0] cnt_q;
  logic [1:0]      idx_q;
  dir_e            dir_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !active_i) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      dir_q <= DIR_UP;
    end else if (cnt_q == NT_W'(NOTE_TICKS - 1)) begin
      cnt_q <= '0;
      if (NUM_NOTES > 1) begin
        case (mode_i)
          MODE_UP:   idx_q <= (idx_q == LAST) ? 2'd0 : idx_q + 2'd1;
          MODE_DOWN: idx_q <= (idx_q == 2'd0) ? LAST : idx_q - 2'd1;
          MODE_UPDOWN: begin
            // ends force a turn-around, so switching into up-down mid-run needs no fix-up
            if (idx_q == LAST) begin
              idx_q <= idx_q - 2'd1;
              dir_q <= DIR_DOWN;
            end else if (idx_q == 2'd0) begin
              idx_q <= 2'd1;
              dir_q <= DIR_UP;
            end else if (dir_q == DIR_UP) begin
              idx_q <= idx_q + 2'd1;
            end else begin
              idx_q <= idx_q - 2'd1;
            end
          end
          default: idx_q <= 2'd0;
        endcase
      end
    end else begin
      cnt_q <= cnt_q + NT_W'(1);
    end
  end

  assign note_idx_o = idx_q;

endmodule

// File: rtl/arp_wavetable_voice.sv
// rtl/arp_wavetable_voice.sv - DDS wavetable voice with arpeggiated pitch ratios
// Tick divider, phase accumulator, ratio multiply and the 2-cycle BRAM-to-sample pipeline.
module arp_wavetable_voice
  import arp_pkg::*;
#(
  parameter int DATA_W     = 11,
  parameter int ADDR_W     = 8,
  parameter int PHASE_W    = 24,
  parameter int INC_W      = 16,
  parameter int NUM_NOTES  = 4,
  parameter int NOTE_TICKS = 50_000_000,
  parameter int TICK_DIV   = 2048
) (
  input  logic              CLK100MHZ,
  input  logic              RST,
  input  logic              arp_en,
  input  logic [1:0]        mode,
  input  logic [INC_W-1:0]  base_inc,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic [1:0]        note_idx
);

  localparam int                TICK_W   = $clog2(TICK_DIV);
  localparam int                PROD_W   = INC_W + RATIO_W;
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic [1:0]         pend_q;
  logic               valid_q;
  logic               en_q;
  logic               tick;
  logic               active;
  logic [1:0]         seq_idx;
  logic [PROD_W-1:0]  prod;
  logic [PHASE_W-1:0] inc;

  assign active = arp_en && (mode != MODE_OFF);

  arp_note_seq #(
    .NUM_NOTES  (NUM_NOTES),
    .NOTE_TICKS (NOTE_TICKS)
  ) u_seq (
    .clk_i      (CLK100MHZ),
    .rst_i      (RST),
    .active_i   (active),
    .mode_i     (mode),
    .note_idx_o (seq_idx)
  );

  // registered note index, so a same-edge note advance still uses the old ratio
  assign prod = PROD_W'(base_inc) * PROD_W'(note_ratio(seq_idx));
  assign inc  = PHASE_W'(prod >> RATIO_FRAC);

  always_comb begin
    tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    phase_d    = tick ? phase_q + inc : phase_q;
    addr_d     = tick ? phase_d[PHASE_W-1 -: ADDR_W] : addr_q;
    sample_d   = pend_q[1] ? rom_data : sample_q;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      tick_cnt_q <= '0;
      phase_q    <= '0;
      addr_q     <= '0;
      sample_q   <= MIDSCALE;
      pend_q     <= 2'b00;
      valid_q    <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      addr_q     <= addr_d;
      sample_q   <= sample_d;
      // pend_q[0]: address presented, pend_q[1]: BRAM data valid next edge
      pend_q     <= {pend_q[0], tick};
      valid_q    <= pend_q[1];
      en_q       <= 1'b1;
    end
  end

  assign rom_en       = en_q;
  assign rom_addr     = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign note_idx     = seq_idx;

endmodule

// File: tb/tb_arp_wavetable_voice.sv
// tb/tb_arp_wavetable_voice.sv - self-checking bench for arp_wavetable_voice
// Cycle model of phase/notes/sample queue plus literal expectations pinning it.
module tb_arp_wavetable_voice;

  localparam int DATA_W     = 11;
  localparam int ADDR_W     = 8;
  localparam int PHASE_W    = 16;
  localparam int INC_W      = 16;
  localparam int NUM_NOTES  = 4;
  localparam int NOTE_TICKS = 32;
  localparam int TICK_DIV   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              arp_en = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [INC_W-1:0]  base_inc = '0;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic [1:0]        note_idx;

  always #5 clk = ~clk;

  arp_wavetable_voice #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W), .INC_W(INC_W),
    .NUM_NOTES(NUM_NOTES), .NOTE_TICKS(NOTE_TICKS), .TICK_DIV(TICK_DIV)
  ) dut (
    .CLK100MHZ(clk), .RST(rst), .arp_en(arp_en), .mode(mode), .base_inc(base_inc),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample_out(sample_out), .sample_valid(sample_valid), .note_idx(note_idx)
  );

  always @(posedge clk) if (rom_en) rom_data <= {3'b000, rom_addr};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int calc_inc(input int b, input int n);
    int r;
    case (n)
      0: r = 256;
      1: r = 320;
      2: r = 384;
      default: r = 512;
    endcase
    return ((b * r) >> 8) % (1 << PHASE_W);
  endfunction

  function automatic int next_note(input int n, input int md, input int d, output int nd);
    nd = d;
    if (md == 1) return (n + 1) % NUM_NOTES;
    if (md == 2) return (n + NUM_NOTES - 1) % NUM_NOTES;
    if (n == NUM_NOTES - 1) begin nd = 1; return n - 1; end
    if (n == 0) begin nd = 0; return 1; end
    return (d != 0) ? n - 1 : n + 1;
  endfunction

  int m_tick, m_phase, m_addr, m_note, m_dir, m_ncnt, m_cyc, m_sample, m_valid, m_en;
  bit m_ok = 1'b0;
  int due_q[$];
  int val_q[$];

  always @(posedge clk) begin
    int nd;
    if (rst) begin
      m_tick = 0; m_phase = 0; m_addr = 0; m_note = 0; m_dir = 0; m_ncnt = 0;
      m_cyc = 0; m_sample = 1 << (DATA_W - 1); m_valid = 0; m_en = 0; m_ok = 1'b1;
      due_q.delete(); val_q.delete();
    end else begin
      m_cyc++;
      m_en = 1;
      m_valid = 0;
      if (due_q.size() > 0 && due_q[0] == m_cyc) begin
        m_sample = val_q[0];
        m_valid = 1;
        void'(due_q.pop_front());
        void'(val_q.pop_front());
      end
      if (m_tick == TICK_DIV - 1) begin
        m_tick = 0;
        m_phase = (m_phase + calc_inc(int'(base_inc), m_note)) % (1 << PHASE_W);
        m_addr = m_phase >> (PHASE_W - ADDR_W);
        due_q.push_back(m_cyc + 2);
        val_q.push_back(m_addr);
      end else begin
        m_tick++;
      end
      if (!(arp_en && mode != 2'd0)) begin
        m_note = 0; m_ncnt = 0; m_dir = 0;
      end else if (m_ncnt == NOTE_TICKS - 1) begin
        m_ncnt = 0;
        m_note = next_note(m_note, int'(mode), m_dir, nd);
        m_dir = nd;
      end else begin
        m_ncnt++;
      end
    end
  end

  int vcount = 0;
  bit rec = 1'b0;
  int last_rec;
  int seq[$];
  int exp_seq[$];

  always @(negedge clk) begin
    if (m_ok) begin
      chk("sample_out", 32'(sample_out), m_sample);
      chk("sample_valid", 32'(sample_valid), m_valid);
      chk("rom_addr", 32'(rom_addr), m_addr);
      chk("note_idx", 32'(note_idx), m_note);
      chk("rom_en", 32'(rom_en), m_en);
      if (sample_valid === 1'b1) vcount++;
      if (rec && int'(note_idx) != last_rec) begin
        seq.push_back(int'(note_idx));
        last_rec = int'(note_idx);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_rec();
    seq.delete();
    seq.push_back(int'(note_idx));
    last_rec = int'(note_idx);
    rec = 1'b1;
  endtask

  task automatic check_seq(input string name);
    rec = 1'b0;
    chk({name, "_len"}, seq.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
      chk(name, seq[i], exp_seq[i]);
  endtask

  task automatic restart(input logic a, input logic [1:0] md, input logic [INC_W-1:0] b);
    rst = 1'b1; arp_en = a; mode = md; base_inc = b;
    step(3);
    rst = 1'b0;
  endtask

  initial begin
    int found;
    rst = 1'b1;
    step(3);
    chk("rst_sample", 32'(sample_out), 32'd1024);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_note", 32'(note_idx), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_en", 32'(rom_en), 32'd0);
    chk("model_inc_n1", calc_inc(32'h100, 1), 32'h140);
    chk("model_inc_wrap", calc_inc(32'hFFFF, 3), 32'hFFFE);

    base_inc = 16'h0100;
    rst = 1'b0;
    vcount = 0;
    step(40);
    chk("base_addr40", 32'(rom_addr), 32'd10);
    chk("base_valids", vcount, 9);

    restart(1'b1, 2'd1, 16'h0100);
    start_rec();
    step(44);
    chk("up_addr44", 32'(rom_addr), 32'h0B);
    step(100);
    exp_seq = '{0, 1, 2, 3, 0};
    check_seq("seq_up");

    restart(1'b1, 2'd3, 16'h0100);
    start_rec();
    step(232);
    exp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};
    check_seq("seq_updown");

    restart(1'b1, 2'd2, 16'h0100);
    start_rec();
    step(136);
    exp_seq = '{0, 3, 2, 1, 0};
    check_seq("seq_down");

    restart(1'b1, 2'd1, 16'h0100);
    step(70);
    chk("drop_pre", 32'(note_idx), 32'd2);
    arp_en = 1'b0;
    step(1);
    chk("drop_post", 32'(note_idx), 32'd0);
    step(20);

    restart(1'b1, 2'd1, 16'hFFFF);
    step(100);
    chk("wrap_note", 32'(note_idx), 32'd3);
    step(40);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (sample_valid === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("wrap_valid_seen", found, 1);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    vcount = 0;
    step(5);
    chk("rst_discard", vcount, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
